// File: rtl/mem_arbiter.sv
// Two-master (I-cache, D-cache) to one main-memory port arbiter with registered memory command.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed D-cache priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              ic_read,
  input  logic              ic_write,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic [DATA_W-1:0] ic_wdata,
  output logic              ic_ready,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                ic_valid_c, dc_valid_c, pick_dc_c;
`ifdef ARB_ROUND_ROBIN_EN
  logic                rr_last_dc_q, rr_last_dc_d;
`endif

  // Arbitration: a requester is valid on read or write; pick_dc_c decides ties.
  always_comb begin
    ic_valid_c = ic_read | ic_write;
    dc_valid_c = dc_read | dc_write;
`ifdef ARB_ROUND_ROBIN_EN
    pick_dc_c  = dc_valid_c & (~ic_valid_c | ~rr_last_dc_q);
`else
    pick_dc_c  = dc_valid_c;
`endif
  end

  // Next-state and memory command latch.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_dc_d = rr_last_dc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ic_valid_c || dc_valid_c) begin
          if (pick_dc_c) begin
            // Write wins over read when both are raised (write-back first).
            mem_write_d = dc_write;
            mem_read_d  = ~dc_write;
            mem_addr_d  = dc_addr;
            mem_wdata_d = dc_wdata;
            state_d     = S_GRANT_D;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_dc_d = 1'b1;
`endif
          end else begin
            mem_write_d = ic_write;
            mem_read_d  = ~ic_write;
            mem_addr_d  = ic_addr;
            mem_wdata_d = ic_wdata;
            state_d     = S_GRANT_I;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_dc_d = 1'b0;
`endif
          end
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q     <= S_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_dc_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_dc_q <= rr_last_dc_d;
`endif
    end
  end

  // Completion is routed combinationally so the cache sees it in the mem_ready cycle.
  assign ic_ready  = (state_q == S_GRANT_I) & mem_ready;
  assign dc_ready  = (state_q == S_GRANT_D) & mem_ready;
  assign ic_rdata  = mem_rdata;
  assign dc_rdata  = mem_rdata;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
